// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle between the fractional baud generator and the
// UART transmitter/receiver. The master side programs the divisor and
// steers enable/sync; the slave side (the generator) returns the ticks.
interface uart_baud_gen_frac_if #(
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  logic              en;
  logic              sync;
  logic              div_load;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;

  logic              s_tick;
  logic              b_tick;
  logic              m_tick;
  logic [OS_W-1:0]   os_phase;

  modport master (
    output en, sync, div_load, div_int, div_frac,
    input  s_tick, b_tick, m_tick, os_phase
  );

  modport slave (
    input  en, sync, div_load, div_int, div_frac,
    output s_tick, b_tick, m_tick, os_phase
  );

endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator. Each oversample period lasts act_int
// clocks, plus one more whenever the fraction accumulator overflows, so
// that over 2^FRAC_W periods exactly act_frac of them are stretched.
// Every period end raises s_tick; b_tick and m_tick mark the last and the
// middle oversample tick of each bit. A divisor loaded while running is
// held pending and swapped in at the next period boundary, so the period
// in flight always completes with the divisor it started with.
module uart_baud_gen_frac #(
  parameter int                OVERSAMPLE = 16,
  parameter int                INT_W      = 16,
  parameter int                FRAC_W     = 4,
  parameter logic [INT_W-1:0]  DEF_INT    = 16'd54,
  parameter logic [FRAC_W-1:0] DEF_FRAC   = 4'd4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_baud_gen_frac_if.slave   bus
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  // Timing state: clocks into the current period, fractional remainder
  // and oversample position within the bit.
  logic [INT_W:0]      cnt;
  logic [FRAC_W-1:0]   acc;
  logic [OS_W-1:0]     os_cnt;

  // Divisor in use and a divisor waiting for the next period boundary.
  logic [INT_W-1:0]    act_int;
  logic [FRAC_W-1:0]   act_frac;
  logic [INT_W-1:0]    pend_int;
  logic [FRAC_W-1:0]   pend_frac;
  logic                pend_v;

  // Set once the generator has seen en high; the first enabled edge after
  // a stop behaves like a sync so the first period is a full P clocks.
  logic                run;

  logic                s_tick_q;
  logic                b_tick_q;
  logic                m_tick_q;

  logic [INT_W-1:0]    int_eff;
  logic [FRAC_W:0]     frac_sum;
  logic                carry;
  logic [INT_W:0]      period;
  logic [INT_W:0]      cnt_inc;
  logic                period_end;
  logic                restart;

  // Length of the period in flight and whether this edge closes it.
  // Integer divisors below 2 are clamped so a period is never shorter
  // than two clocks.
  always_comb begin
    int_eff    = (act_int < INT_W'(2)) ? INT_W'(2) : act_int;
    frac_sum   = {1'b0, acc} + {1'b0, act_frac};
    carry      = frac_sum[FRAC_W];
    period     = {1'b0, int_eff} + {{INT_W{1'b0}}, carry};
    cnt_inc    = cnt + {{INT_W{1'b0}}, 1'b1};
    period_end = (cnt_inc == period);
    restart    = bus.sync || !run;
  end

  // Main sequencer: stop / restart / period end / plain count, in that
  // priority, with divisor loading folded into each case.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      os_cnt    <= '0;
      act_int   <= DEF_INT;
      act_frac  <= DEF_FRAC;
      pend_int  <= '0;
      pend_frac <= '0;
      pend_v    <= 1'b0;
      run       <= 1'b0;
      s_tick_q  <= 1'b0;
      b_tick_q  <= 1'b0;
      m_tick_q  <= 1'b0;
    end else begin
      s_tick_q <= 1'b0;
      b_tick_q <= 1'b0;
      m_tick_q <= 1'b0;
      if (!bus.en) begin
        cnt    <= '0;
        acc    <= '0;
        os_cnt <= '0;
        run    <= 1'b0;
        if (bus.div_load) begin
          act_int  <= bus.div_int;
          act_frac <= bus.div_frac;
          pend_v   <= 1'b0;
        end
      end else if (restart) begin
        run    <= 1'b1;
        cnt    <= '0;
        acc    <= '0;
        os_cnt <= '0;
        if (bus.div_load) begin
          act_int  <= bus.div_int;
          act_frac <= bus.div_frac;
          pend_v   <= 1'b0;
        end else if (pend_v) begin
          act_int  <= pend_int;
          act_frac <= pend_frac;
          pend_v   <= 1'b0;
        end
      end else if (period_end) begin
        cnt      <= '0;
        acc      <= frac_sum[FRAC_W-1:0];
        os_cnt   <= os_cnt + OS_W'(1);
        s_tick_q <= 1'b1;
        b_tick_q <= (os_cnt == OS_LAST);
        m_tick_q <= (os_cnt == OS_MID);
        if (bus.div_load) begin
          act_int  <= bus.div_int;
          act_frac <= bus.div_frac;
          pend_v   <= 1'b0;
        end else if (pend_v) begin
          act_int  <= pend_int;
          act_frac <= pend_frac;
          pend_v   <= 1'b0;
        end
      end else begin
        cnt <= cnt_inc;
        if (bus.div_load) begin
          pend_int  <= bus.div_int;
          pend_frac <= bus.div_frac;
          pend_v    <= 1'b1;
        end
      end
    end
  end

  assign bus.s_tick   = s_tick_q;
  assign bus.b_tick   = b_tick_q;
  assign bus.m_tick   = m_tick_q;
  assign bus.os_phase = os_cnt;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac. A schedule-based model
// (absolute cycle of the next period end, plain modular arithmetic for the
// fraction) predicts every output each cycle; directed scenarios also
// check tick gaps and latencies against fixed numbers.
module tb_uart_baud_gen_frac;

  localparam int OS = 16;
  localparam int IW = 16;
  localparam int FW = 4;
  localparam int DI = 54;
  localparam int DF = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.OVERSAMPLE(OS), .INT_W(IW), .FRAC_W(FW)) bus ();

  uart_baud_gen_frac #(
    .OVERSAMPLE(OS), .INT_W(IW), .FRAC_W(FW),
    .DEF_INT(16'd54), .DEF_FRAC(4'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_int = DI, m_frac = DF, m_pend_int = 0, m_pend_frac = 0;
  int m_pend_v = 0, m_acc = 0, m_phase = 0, m_run = 0, m_next = 0;
  int e_s = 0, e_b = 0, e_m = 0, e_ph = 0;

  int tick_q[$];
  int ph_q[$];
  int b_q[$];
  int m_q[$];
  int e0;
  int t_ref;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int periodLen();
    int eff;
    eff = (m_int < 2) ? 2 : m_int;
    return eff + (((m_acc + m_frac) >= (1 << FW)) ? 1 : 0);
  endfunction

  function automatic int tickAt(input int i);
    return (i < tick_q.size()) ? tick_q[i] : -1;
  endfunction

  task automatic takeDivisor(input logic l, input int di, input int df);
    if (l) begin
      m_int = di; m_frac = df; m_pend_v = 0;
    end else if (m_pend_v != 0) begin
      m_int = m_pend_int; m_frac = m_pend_frac; m_pend_v = 0;
    end
  endtask

  task automatic modelEdge(input logic r, input logic e, input logic s, input logic l,
                           input int di, input int df);
    e_s = 0; e_b = 0; e_m = 0;
    if (r) begin
      m_int = DI; m_frac = DF; m_pend_v = 0; m_acc = 0; m_phase = 0; m_run = 0;
    end else if (!e) begin
      m_acc = 0; m_phase = 0; m_run = 0;
      if (l) begin
        m_int = di; m_frac = df; m_pend_v = 0;
      end
    end else if (m_run == 0 || s) begin
      m_run = 1; m_acc = 0; m_phase = 0;
      takeDivisor(l, di, df);
      m_next = cyc + periodLen();
    end else if (cyc == m_next) begin
      e_s = 1;
      e_b = (m_phase == OS - 1) ? 1 : 0;
      e_m = (m_phase == OS / 2 - 1) ? 1 : 0;
      m_phase = (m_phase + 1) % OS;
      m_acc = (m_acc + m_frac) % (1 << FW);
      takeDivisor(l, di, df);
      m_next = cyc + periodLen();
    end else if (l) begin
      m_pend_int = di; m_pend_frac = df; m_pend_v = 1;
    end
    e_ph = m_phase;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic l,
                               input int di, input int df);
    reset        = r;
    bus.en       = e;
    bus.sync     = s;
    bus.div_load = l;
    bus.div_int  = di[IW-1:0];
    bus.div_frac = df[FW-1:0];
    @(posedge clk);
    cyc++;
    modelEdge(r, e, s, l, di, df);
    #1;
    checkOutput("s_tick", {31'b0, bus.s_tick}, e_s);
    checkOutput("b_tick", {31'b0, bus.b_tick}, e_b);
    checkOutput("m_tick", {31'b0, bus.m_tick}, e_m);
    checkOutput("os_phase", {28'b0, bus.os_phase}, e_ph);
    if (bus.s_tick === 1'b1) begin
      tick_q.push_back(cyc);
      ph_q.push_back(int'(bus.os_phase));
      if (bus.b_tick === 1'b1) b_q.push_back(cyc);
      if (bus.m_tick === 1'b1) m_q.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic clearLogs();
    tick_q.delete(); ph_q.delete(); b_q.delete(); m_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.sync = 1'b0; bus.div_load = 1'b0;
    bus.div_int = '0; bus.div_frac = '0;
    @(negedge clk);

    $display("[TB] reset defaults");
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_s_tick", {31'b0, bus.s_tick}, 0);
    checkOutput("rst_os_phase", {28'b0, bus.os_phase}, 0);

    $display("[TB] default divisor 54.25");
    clearLogs();
    e0 = cyc + 1;
    repeat (869) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("A_tick_count", tick_q.size(), 16);
    checkOutput("A_first_latency", tickAt(0) - e0, 54);
    checkOutput("A_gap1", tickAt(1) - tickAt(0), 54);
    checkOutput("A_gap2", tickAt(2) - tickAt(1), 54);
    checkOutput("A_gap3", tickAt(3) - tickAt(2), 55);
    checkOutput("A_b_count", b_q.size(), 1);
    checkOutput("A_b_on_16th", (b_q.size() > 0) ? b_q[0] : -1, tickAt(15));
    checkOutput("A_m_count", m_q.size(), 1);
    checkOutput("A_m_on_8th", (m_q.size() > 0) ? m_q[0] : -1, tickAt(7));

    $display("[TB] direct load 10 while stopped");
    applyStimulus(0, 0, 0, 1, 10, 0);
    checkOutput("B_stop_s_tick", {31'b0, bus.s_tick}, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    clearLogs();
    e0 = cyc + 1;
    repeat (331) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("B_first_latency", tickAt(0) - e0, 10);
    checkOutput("B_gap", tickAt(1) - tickAt(0), 10);
    checkOutput("B_tick_count", tick_q.size(), 33);
    checkOutput("B_b_count", b_q.size(), 2);
    checkOutput("B_b_gap", (b_q.size() > 1) ? b_q[1] - b_q[0] : -1, 160);

    $display("[TB] pending load 20 three clocks after a tick");
    checkOutput("C_ref_tick", {31'b0, bus.s_tick}, 1);
    t_ref = cyc;
    clearLogs();
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 20, 0);
    repeat (80) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("C_gap_old", tickAt(0) - t_ref, 10);
    checkOutput("C_gap_new1", tickAt(1) - tickAt(0), 20);
    checkOutput("C_gap_new2", tickAt(2) - tickAt(1), 20);
    checkOutput("C_phase_cont", (ph_q.size() > 0) ? ph_q[0] : -1, 2);

    $display("[TB] sync at a random cycle");
    repeat ($urandom_range(1, 19)) applyStimulus(0, 1, 0, 0, 0, 0);
    e0 = cyc + 1;
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("D_sync_no_tick", {31'b0, bus.s_tick}, 0);
    checkOutput("D_sync_phase", {28'b0, bus.os_phase}, 0);
    clearLogs();
    repeat (165) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("D_first_latency", tickAt(0) - e0, 20);
    checkOutput("D_first_phase", (ph_q.size() > 0) ? ph_q[0] : -1, 1);
    checkOutput("D_m_on_8th", (m_q.size() > 0) ? m_q[0] : -1, tickAt(7));

    $display("[TB] minimum divisor clamp");
    applyStimulus(0, 0, 0, 1, 1, 0);
    clearLogs();
    e0 = cyc + 1;
    repeat (21) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("E1_first_latency", tickAt(0) - e0, 2);
    checkOutput("E1_gap", tickAt(1) - tickAt(0), 2);
    checkOutput("E1_count", tick_q.size(), 10);
    applyStimulus(0, 0, 0, 1, 0, 0);
    clearLogs();
    e0 = cyc + 1;
    repeat (21) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("E0_first_latency", tickAt(0) - e0, 2);
    checkOutput("E0_gap", tickAt(1) - tickAt(0), 2);
    checkOutput("E0_count", tick_q.size(), 10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(0,
                    ($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 39) == 0),
                    int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 15)));
    end

    $display("[TB] reset with a pending divisor, then en drop");
    applyStimulus(0, 0, 0, 1, 30, 0);
    e0 = cyc + 1;
    repeat (41) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 7, 0);
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("G_rst_s_tick", {31'b0, bus.s_tick}, 0);
    checkOutput("G_rst_b_tick", {31'b0, bus.b_tick}, 0);
    checkOutput("G_rst_os_phase", {28'b0, bus.os_phase}, 0);
    clearLogs();
    e0 = cyc + 1;
    repeat (60) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("G_default_latency", tickAt(0) - e0, 54);
    checkOutput("G_default_count", tick_q.size(), 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("G_stopped_s_tick", {31'b0, bus.s_tick}, 0);
    clearLogs();
    e0 = cyc + 1;
    repeat (60) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("G_reenable_latency", tickAt(0) - e0, 54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Programmable fractional baud-rate generator for the UART. Produces a 1-clock oversampling tick (`s_tick`), a bit-rate tick (`b_tick`) and a mid-bit tick (`m_tick`) from a runtime-loadable divisor with an integer and a fractional part, which keeps baud error low at any clock frequency. A `sync` input realigns the tick phase so the receiver can lock to a start-bit edge. It drives both the UART transmitter and receiver.

## Interface
- `OVERSAMPLE`, 16: `s_tick`s per bit; power of two, ≥ 4.
- `INT_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor (units of 1/2^FRAC_W clock).
- `DEF_INT`, 54: active integer divisor after reset (100 MHz, 115200 baud, x16).
- `DEF_FRAC`, 4: active fractional divisor after reset (0.25).
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: generator enable.
- `sync` in 1: phase restart pulse.
- `div_load` in 1: load strobe for `div_int`/`div_frac`.
- `div_int` in INT_W: integer clocks per `s_tick`.
- `div_frac` in FRAC_W: fractional clocks per `s_tick`.
- `s_tick` out 1: oversample tick, one clock wide.
- `b_tick` out 1: bit tick, one clock wide, coincident with every OVERSAMPLE-th `s_tick`.
- `m_tick` out 1: mid-bit tick, coincident with the (OVERSAMPLE/2)-th `s_tick` of each bit.
- `os_phase` out $clog2(OVERSAMPLE): count of `s_tick`s within the current bit.

## Operation
- State: period counter `cnt` (INT_W+1), fraction accumulator `acc` (FRAC_W), oversample counter `os_cnt`, active divisor `act_int`/`act_frac`, pending divisor `pend_int`/`pend_frac` plus `pend_v`.
- Period length P_k = `act_int` + c_k. c_k is the carry out of `acc` + `act_frac`, and `acc` takes the sum bits when period k ends. `acc` starts at 0 after reset, `en` low, or `sync`.
- Over 2^FRAC_W periods, exactly `act_frac` periods are extended by one clock.
- `act_int` values 0 and 1 are treated as 2. The minimum period is 2 clocks.
- Each period end raises `s_tick` and increments `os_cnt`, which wraps from OVERSAMPLE-1 to 0.
- `b_tick` = `s_tick` while `os_cnt` == OVERSAMPLE-1. `m_tick` = `s_tick` while `os_cnt` == OVERSAMPLE/2-1.
- `div_load` with `en` = 0: the new value is written directly into `act_*`.
- `div_load` with `en` = 1: the value is stored in `pend_*` and `pend_v` is set. `act_*` takes the pending value at the next period end, so the current period finishes with the old divisor.
- A later `div_load` overwrites the pending value.
- `en` = 0: `cnt`, `acc` and `os_cnt` clear to 0. All ticks are 0. `act_*` is held.
- `sync` = 1 with `en` = 1: `cnt`, `acc` and `os_cnt` clear. No tick is raised that cycle. A pending divisor is applied immediately.
- Priority: `reset` > `en` low > `sync` > period end > `div_load`.
- `div_load` and `sync` in the same cycle: the loaded value is used for the restarted period.
- `div_load` and a period end in the same cycle: the loaded value is used from the next period on.

## Timing
- Reset values: `s_tick`, `b_tick`, `m_tick` = 0. `os_phase` = 0. `act_*` = `DEF_*`. `pend_v` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let rising edge E0 be the first edge that samples `en` = 1 (or samples `sync` = 1). The first `s_tick` is high for the single cycle after edge E0+P_1.
- Each later `s_tick` follows the previous one by exactly P_k clocks.
- `os_phase` updates in the same cycle that `s_tick` is high and shows the post-increment value.
- When `en` is sampled low, all ticks are 0 from the next cycle. A tick already high in the current cycle is not extended.

## Test plan
- Reset defaults, `en` = 1 for 868 clocks → `s_tick` gaps repeat 54, 54, 54, 55. Exactly 16 `s_tick`s occur in 868 clocks. One `b_tick` coincides with the 16th `s_tick`. `m_tick` coincides with the 8th.
- `en` = 0, load `div_int` = 10, `div_frac` = 0, then `en` = 1 → `s_tick` every 10 clocks. First tick high in the cycle after edge E0+10. `b_tick` every 160 clocks.
- Running at divisor 10; `div_load` 20 arrives 3 clocks after an `s_tick` → the next gap is still 10, all following gaps are 20. `os_phase` continuity is kept.
- Running; `sync` pulse at an arbitrary cycle → no tick that cycle. Next `s_tick` is exactly P clocks later. `os_phase` restarts at 1, and `m_tick` falls on the 8th `s_tick` after `sync`.
- `div_int` = 1, `div_frac` = 0 → `s_tick` every 2 clocks. `div_int` = 0 → same result.
- `reset` asserted mid-bit with `pend_v` = 1 → the next cycle has all ticks 0, `act_*` = 54/4, and the pending value discarded. Assert `en` low mid-period → ticks stop, and re-enabling gives the first tick P_1 clocks later.
